// File: rtl/vehicle_control_pkg.sv
// -----------------------------------------------------------------------------
// vehicle_control_pkg
//   Shared types and codes for the vehicle body-control block.
//   - gear_e     : registered gear state encoding
//   - turn_e     : registered turn-indicator encoding (2'b10 is never used)
//   - GEAR_REQ_* : gear-selector request codes on _gearShift
//   - LEVER_*    : turn-lever push codes on _turnShift
// -----------------------------------------------------------------------------
package vehicle_control_pkg;

  typedef enum logic [1:0] {
    LOCK    = 2'b00,
    PARKING = 2'b01,
    REVERSE = 2'b10,
    FORWARD = 2'b11
  } gear_e;

  typedef enum logic [1:0] {
    NO_TURN    = 2'b00,
    LEFT_TURN  = 2'b01,
    RIGHT_TURN = 2'b11
  } turn_e;

  localparam logic [1:0] GEAR_REQ_PARK = 2'b00;
  localparam logic [1:0] GEAR_REQ_REV  = 2'b01;
  localparam logic [1:0] GEAR_REQ_HOLD = 2'b10;
  localparam logic [1:0] GEAR_REQ_FWD  = 2'b11;

  localparam logic [1:0] LEVER_LEFT  = 2'b01;
  localparam logic [1:0] LEVER_RIGHT = 2'b10;

  // Indicators may only be lit while the vehicle is in a driving gear.
  function automatic logic turnAllowed(gear_e gear);
    return (gear == REVERSE) || (gear == FORWARD);
  endfunction

endpackage

// File: rtl/vehicle_blinker.sv
// -----------------------------------------------------------------------------
// vehicle_blinker
//   Lamp flasher for the turn indicators. Only instantiated when the
//   VEHICLE_BLINK_EN macro is defined.
//   The lamp for the active direction comes on the cycle after the indicator
//   becomes active and then toggles every BLINK_HALF_PERIOD cycles. Counter
//   and phase clear while the indicator is off.
// Parameters
//   BLINK_HALF_PERIOD  clock cycles per lamp on/off phase (>= 1)
// Ports
//   clock       in   system clock, rising edge
//   _reset_n    in   asynchronous active-low reset
//   _turnState  in   registered turn-indicator state
//   _leftLamp   out  left lamp drive
//   _rightLamp  out  right lamp drive
// -----------------------------------------------------------------------------
module vehicle_blinker
  import vehicle_control_pkg::*;
#(
  parameter int BLINK_HALF_PERIOD = 4
) (
  input  logic  clock,
  input  logic  _reset_n,
  input  turn_e _turnState,
  output logic  _leftLamp,
  output logic  _rightLamp
);

  localparam int CntW = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_HALF_PERIOD - 1);

  logic [CntW-1:0] blinkCnt;
  logic            blinkPhase;

  always_ff @(posedge clock or negedge _reset_n) begin
    if (!_reset_n) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (_turnState == NO_TURN) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else begin
      // Toggling at count zero makes the first active edge switch the lamp on.
      if (blinkCnt == '0) blinkPhase <= ~blinkPhase;
      blinkCnt <= (blinkCnt == CntLast) ? '0 : blinkCnt + CntW'(1);
    end
  end

  // Masking with the registered state blanks the lamps on the same edge the
  // indicator turns off; both terms are registers, so no combinational glitch
  // path from the inputs.
  assign _leftLamp  = blinkPhase && (_turnState == LEFT_TURN);
  assign _rightLamp = blinkPhase && (_turnState == RIGHT_TURN);

endmodule

// File: rtl/vehicle_control.sv
// -----------------------------------------------------------------------------
// vehicle_control
//   Vehicle body-control FSMs: ignition, gear selector and turn lever in,
//   registered gear and turn-indicator state out. Gear and turn machines are
//   independent registers; the turn machine looks at the *next* gear so a gear
//   change and a lever press on the same edge are resolved consistently.
// Configuration
//   VEHICLE_BLINK_EN  when defined, adds BLINK_HALF_PERIOD, the vehicle_blinker
//                     instance and the _leftLamp/_rightLamp ports.
// Ports
//   clock       in   1  system clock, rising edge
//   _reset_n    in   1  asynchronous active-low reset
//   _switch     in   1  ignition: 1 = ON, 0 = OFF
//   _gearShift  in   2  gear request (GEAR_REQ_*)
//   _turnShift  in   2  turn lever (LEVER_LEFT / LEVER_RIGHT, else idle)
//   _gearState  out  2  gear_e, registered
//   _turnState  out  2  turn_e, registered
//   _leftLamp   out  1  blinking left lamp  (VEHICLE_BLINK_EN only)
//   _rightLamp  out  1  blinking right lamp (VEHICLE_BLINK_EN only)
// -----------------------------------------------------------------------------
module vehicle_control
  import vehicle_control_pkg::*;
`ifdef VEHICLE_BLINK_EN
#(
  parameter int BLINK_HALF_PERIOD = 4
)
`endif
(
  input  logic       clock,
  input  logic       _reset_n,
  input  logic       _switch,
  input  logic [1:0] _gearShift,
  input  logic [1:0] _turnShift,
  output logic [1:0] _gearState,
  output logic [1:0] _turnState
`ifdef VEHICLE_BLINK_EN
  ,
  output logic       _leftLamp,
  output logic       _rightLamp
`endif
);

  gear_e      gearState, gearNext;
  turn_e      turnState, turnNext;
  logic [1:0] leverPrev;
  logic       leverChanged, leftPress, rightPress;

  // State registers. The lever history samples every cycle, even with the
  // ignition off, so a lever held through power-up is not seen as a press.
  always_ff @(posedge clock or negedge _reset_n) begin
    if (!_reset_n) begin
      gearState <= LOCK;
      turnState <= NO_TURN;
      leverPrev <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make every register see the pre-edge
      // values of the others, regardless of statement order.
      gearState <= gearNext;
      turnState <= turnNext;
      leverPrev <= _turnShift;
    end
  end

  // Gear next-state: ignition off dominates, LOCK always goes to PARKING first.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives gearNext,
    // so no latch is inferred.
    gearNext = gearState;
    if (!_switch) begin
      gearNext = LOCK;
    end else if (gearState == LOCK) begin
      gearNext = PARKING;
    end else begin
      case (_gearShift)
        GEAR_REQ_PARK: gearNext = PARKING;
        GEAR_REQ_REV:  gearNext = REVERSE;
        GEAR_REQ_FWD:  gearNext = FORWARD;
        GEAR_REQ_HOLD: gearNext = gearState;
      endcase
    end
  end

  // A press is an edge into a push code; holding the lever is not a press.
  assign leverChanged = (_turnShift != leverPrev);
  assign leftPress    = leverChanged && (_turnShift == LEVER_LEFT);
  assign rightPress   = leverChanged && (_turnShift == LEVER_RIGHT);

  // Turn next-state, evaluated against the gear the vehicle is moving into.
  always_comb begin
    turnNext = turnState;
    if (!turnAllowed(gearNext)) begin
      turnNext = NO_TURN;
    end else begin
      case (turnState)
        NO_TURN: begin
          if (leftPress)       turnNext = LEFT_TURN;
          else if (rightPress) turnNext = RIGHT_TURN;
        end
        LEFT_TURN:  if (rightPress) turnNext = NO_TURN;
        RIGHT_TURN: if (leftPress)  turnNext = NO_TURN;
        default:    turnNext = NO_TURN;
      endcase
    end
  end

  assign _gearState = gearState;
  assign _turnState = turnState;

`ifdef VEHICLE_BLINK_EN
  vehicle_blinker #(
    .BLINK_HALF_PERIOD(BLINK_HALF_PERIOD)
  ) blinker (
    .clock      (clock),
    ._reset_n   (_reset_n),
    ._turnState (turnState),
    ._leftLamp  (_leftLamp),
    ._rightLamp (_rightLamp)
  );
`endif

endmodule

// File: tb/tb_vehicle_control.sv
// -----------------------------------------------------------------------------
// tb_vehicle_control
//   Self-checking bench for vehicle_control: directed scenarios followed by
//   randomized stimulus, all compared against a behavioural model of the
//   driver-visible rules. Lamp checks are compiled in with VEHICLE_BLINK_EN.
// -----------------------------------------------------------------------------
module tb_vehicle_control;

  localparam int HALF = 4;

  logic       clock;
  logic       _reset_n;
  logic       _switch;
  logic [1:0] _gearShift;
  logic [1:0] _turnShift;
  logic [1:0] _gearState;
  logic [1:0] _turnState;
`ifdef VEHICLE_BLINK_EN
  logic       _leftLamp;
  logic       _rightLamp;
`endif

  vehicle_control dut (
    .clock      (clock),
    ._reset_n   (_reset_n),
    ._switch    (_switch),
    ._gearShift (_gearShift),
    ._turnShift (_turnShift),
    ._gearState (_gearState),
    ._turnState (_turnState)
`ifdef VEHICLE_BLINK_EN
    ,
    ._leftLamp  (_leftLamp),
    ._rightLamp (_rightLamp)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: gear as 0 LOCK / 1 PARKING / 2 REVERSE / 3 FORWARD,
  // turn direction as -1 left / 0 none / +1 right.
  int         mGear;
  int         mDir;
  logic [1:0] mPrevLever;
`ifdef VEHICLE_BLINK_EN
  int         mActiveEdges;  // edges clocked while an indicator was on
`endif

  task automatic check(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic int turnCode(input int dir);
    if (dir < 0) return 1;
    if (dir > 0) return 3;
    return 0;
  endfunction

  task automatic modelReset();
    mGear      = 0;
    mDir       = 0;
    mPrevLever = 2'b00;
`ifdef VEHICLE_BLINK_EN
    mActiveEdges = 0;
`endif
  endtask

  task automatic modelEdge(input logic sw, input logic [1:0] gs, input logic [1:0] ts);
    int  reqGear[4];
    int  nextGear;
    bit  leftPress, rightPress;
    reqGear = '{1, 2, -1, 3};  // requests 00,01,10,11; -1 = keep
`ifdef VEHICLE_BLINK_EN
    mActiveEdges = (mDir != 0) ? mActiveEdges + 1 : 0;
`endif
    if (!sw)            nextGear = 0;
    else if (mGear == 0) nextGear = 1;
    else if (reqGear[gs] < 0) nextGear = mGear;
    else                nextGear = reqGear[gs];
    leftPress  = (ts == 2'b01) && (mPrevLever != 2'b01);
    rightPress = (ts == 2'b10) && (mPrevLever != 2'b10);
    if (nextGear < 2)    mDir = 0;
    else if (leftPress)  mDir = (mDir > 0) ? 0 : -1;
    else if (rightPress) mDir = (mDir < 0) ? 0 : 1;
    mPrevLever = ts;
    mGear      = nextGear;
  endtask

  task automatic checkAll(input string tag);
`ifdef VEHICLE_BLINK_EN
    bit lampOn;
`endif
    check({tag, "_gear"}, int'(_gearState), mGear);
    check({tag, "_turn"}, int'(_turnState), turnCode(mDir));
`ifdef VEHICLE_BLINK_EN
    lampOn = (mActiveEdges >= 1) && ((((mActiveEdges - 1) / HALF) % 2) == 0);
    check({tag, "_left"},  int'(_leftLamp),  int'(lampOn && mDir < 0));
    check({tag, "_right"}, int'(_rightLamp), int'(lampOn && mDir > 0));
`endif
  endtask

  // Drive inputs between edges, clock once, compare 1 time unit later.
  task automatic step(input logic sw, input logic [1:0] gs, input logic [1:0] ts,
                      input string tag);
    _switch    = sw;
    _gearShift = gs;
    _turnShift = ts;
    @(posedge clock);
    modelEdge(sw, gs, ts);
    #1;
    checkAll(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, held across one edge.
  task automatic resetPulse(input string tag);
    #3;
    _reset_n = 1'b0;
    modelReset();
    #1;
    checkAll({tag, "_async"});
    @(posedge clock);
    #1;
    checkAll({tag, "_held"});
    #3;
    _reset_n = 1'b1;
  endtask

  initial begin
    logic       rSw;
    logic [1:0] rGs, rTs;

    _reset_n   = 1'b0;
    _switch    = 1'b0;
    _gearShift = 2'b00;
    _turnShift = 2'b00;
    modelReset();
    #12;
    checkAll("reset");
    check("reset_gear_lock", int'(_gearState), 0);
    _reset_n = 1'b1;

    // 1: ignition off keeps LOCK / NO_TURN
    repeat (3) step(1'b0, 2'b00, 2'b00, "off");
    check("off_lock", int'(_gearState), 0);

    // 2: gear walk PARKING -> REVERSE -> FORWARD, then hold
    step(1'b1, 2'b00, 2'b00, "park");
    check("park_code", int'(_gearState), 1);
    step(1'b1, 2'b01, 2'b00, "rev");
    check("rev_code", int'(_gearState), 2);
    step(1'b1, 2'b11, 2'b00, "fwd");
    check("fwd_code", int'(_gearState), 3);
    repeat (3) step(1'b1, 2'b11, 2'b00, "fwd_hold");
    check("fwd_held", int'(_gearState), 3);

    // 3: right press, hold, left press cancels, held left stays off
    step(1'b1, 2'b11, 2'b10, "right");
    check("right_code", int'(_turnState), 3);
    repeat (2) step(1'b1, 2'b11, 2'b10, "right_hold");
    step(1'b1, 2'b11, 2'b01, "cancel");
    check("cancel_code", int'(_turnState), 0);
    repeat (2) step(1'b1, 2'b11, 2'b01, "cancel_hold");
    check("cancel_held", int'(_turnState), 0);

    // 4: left indicator held long enough to see several lamp phases
    step(1'b1, 2'b11, 2'b00, "idle");
    step(1'b1, 2'b11, 2'b01, "left");
    check("left_code", int'(_turnState), 1);
    repeat (10) step(1'b1, 2'b11, 2'b01, "left_blink");
    step(1'b1, 2'b11, 2'b10, "left_off");
    check("left_off_code", int'(_turnState), 0);

    // 5: gear to PARKING kills an active indicator on the same edge
    step(1'b1, 2'b11, 2'b00, "idle2");
    step(1'b1, 2'b11, 2'b10, "right2");
    step(1'b1, 2'b00, 2'b10, "to_park");
    check("to_park_gear", int'(_gearState), 1);
    check("to_park_turn", int'(_turnState), 0);
    step(1'b1, 2'b00, 2'b00, "park_idle");
    step(1'b1, 2'b00, 2'b01, "park_press");
    check("park_press_turn", int'(_turnState), 0);
    // gear change into FORWARD plus a press on the same edge lights it
    step(1'b1, 2'b11, 2'b10, "fwd_press");
    check("fwd_press_turn", int'(_turnState), 3);

    // 6: ignition off from FORWARD+LEFT, then async reset from FORWARD+LEFT
    step(1'b1, 2'b11, 2'b00, "idle3");
    step(1'b1, 2'b11, 2'b01, "left3");
    step(1'b0, 2'b11, 2'b01, "ign_off");
    check("ign_off_gear", int'(_gearState), 0);
    check("ign_off_turn", int'(_turnState), 0);
    step(1'b1, 2'b11, 2'b00, "relock");
    step(1'b1, 2'b11, 2'b00, "refwd");
    step(1'b1, 2'b11, 2'b01, "left4");
    check("left4_turn", int'(_turnState), 1);
    resetPulse("midreset");
    check("midreset_gear", int'(_gearState), 0);

    // Randomized traffic with occasional asynchronous resets
    rTs = 2'b00;
    rGs = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        resetPulse("rand_reset");
      end else begin
        rSw = ($urandom_range(0, 15) != 0);
        if ($urandom_range(0, 1) == 0) rGs = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) rTs = 2'($urandom_range(0, 3));
        step(rSw, rGs, rTs, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
